// File: rtl/irq_arbiter.sv
// irq_arbiter: shares the processor's single interrupt line among NUM_SRC
// peripherals. Rising edges on SRC_RAISE are captured into PENDING, masked,
// and prioritised (fixed or round-robin). One request at a time is presented
// on IRQ_RAISE, and the processor's IRQ_ACK is returned to the granted source
// as a one-cycle SRC_ACK pulse. MASK/PENDING/VECTOR/CTRL sit on the shared bus.
//
// Ports:
//   CLK        system clock
//   RESET      synchronous active-high reset
//   BUS_DATA   shared 8-bit data bus, driven only in the cycle after a read hit
//   BUS_ADDR   bus address; BASE_ADDR..BASE_ADDR+3 decode to this block
//   BUS_WE     bus write enable (1 = write)
//   SRC_RAISE  per-source request, held high until that source's SRC_ACK
//   SRC_ACK    one-cycle acknowledge to the serviced source
//   IRQ_RAISE  interrupt request to the processor
//   IRQ_ACK    processor acknowledge, one-cycle pulse
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a non-empty eligible set
// S_GRANT | pick the winner, latch VECTOR
// S_RAISE | IRQ_RAISE held until IRQ_ACK; grant is committed here
// S_GAP   | in-service flag cleared, one idle cycle before re-arbitration
module irq_arbiter #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_RAISE,
    output logic [NUM_SRC-1:0] SRC_ACK,
    output logic               IRQ_RAISE,
    input  logic               IRQ_ACK
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RAISE, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] mask, pending, pending_nxt, src_q;
    logic [NUM_SRC-1:0] rise, eligible, idx_onehot, w1c, wdata;
    logic               rr_mode, g_en, vec_valid;
    logic [2:0]         vec_idx, rr_ptr, win_idx;
    logic               win_found;
    logic [15:0]        elig_ext;
    logic [3:0]         cand;
    logic [7:0]         offset, rd_data, rd_q;
    logic [1:0]         reg_sel;
    logic               hit, wr, rd_en_q;
    logic               unused_bus;

    // Subtracting the base keeps the decode correct for unaligned BASE_ADDR.
    assign offset     = BUS_ADDR - BASE_ADDR;
    assign hit        = (offset[7:2] == 6'd0);
    assign reg_sel    = offset[1:0];
    assign wr         = hit & BUS_WE;
    assign wdata      = BUS_DATA[NUM_SRC-1:0];
    assign unused_bus = ^BUS_DATA;

    assign rise       = SRC_RAISE & ~src_q;
    assign eligible   = pending & mask & {NUM_SRC{g_en}};
    assign idx_onehot = NUM_SRC'(1) << vec_idx;

    // Winner search: start at rr_ptr in round-robin mode, else at 0, wrapping
    // at NUM_SRC. Widened copy of the eligible set avoids a narrow index.
    always_comb begin
        elig_ext  = 16'(eligible);
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = 4'(k) + (rr_mode ? {1'b0, rr_ptr} : 4'd0);
            if (cand >= 4'(NUM_SRC))
                cand = cand - 4'(NUM_SRC);
            if (!win_found && elig_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    // PENDING: W1C first, then the ACK clear, then new edges, so a capture in
    // the same cycle as a clear always wins. The committed source is shielded
    // from W1C while its request is on the line.
    always_comb begin
        w1c         = '0;
        pending_nxt = pending;
        if (wr && reg_sel == 2'd1) begin
            w1c = wdata;
            if (state == S_RAISE)
                w1c = w1c & ~idx_onehot;
        end
        pending_nxt = pending_nxt & ~w1c;
        if (state == S_RAISE && IRQ_ACK)
            pending_nxt = pending_nxt & ~idx_onehot;
        pending_nxt = pending_nxt | rise;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (|eligible) state_nxt = S_GRANT;
            S_GRANT: state_nxt = win_found ? S_RAISE : S_IDLE;
            S_RAISE: if (IRQ_ACK) state_nxt = S_GAP;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        unique case (reg_sel)
            2'd0:    rd_data = 8'(mask);
            2'd1:    rd_data = 8'(pending);
            2'd2:    rd_data = {vec_valid, 4'b0000, vec_idx};
            default: rd_data = {6'd0, g_en, rr_mode};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            src_q     <= '0;
            mask      <= '1;
            pending   <= '0;
            rr_mode   <= 1'b0;
            g_en      <= 1'b1;
            vec_valid <= 1'b0;
            vec_idx   <= 3'd0;
            rr_ptr    <= 3'd0;
            SRC_ACK   <= '0;
            rd_en_q   <= 1'b0;
            rd_q      <= 8'h00;
        end else begin
            state   <= state_nxt;
            src_q   <= SRC_RAISE;
            pending <= pending_nxt;
            rd_en_q <= hit & ~BUS_WE;
            rd_q    <= rd_data;
            SRC_ACK <= '0;
            if (wr && reg_sel == 2'd0)
                mask <= wdata;
            if (wr && reg_sel == 2'd3) begin
                rr_mode <= BUS_DATA[0];
                g_en    <= BUS_DATA[1];
            end
            if (state == S_GRANT && win_found) begin
                vec_valid <= 1'b1;
                vec_idx   <= win_idx;
            end
            if (state == S_RAISE && IRQ_ACK) begin
                SRC_ACK <= idx_onehot;
                rr_ptr  <= (vec_idx == 3'(NUM_SRC - 1)) ? 3'd0 : vec_idx + 3'd1;
            end
            if (state == S_GAP)
                vec_valid <= 1'b0;
        end
    end

    assign IRQ_RAISE = (state == S_RAISE);
    assign BUS_DATA  = rd_en_q ? rd_q : 8'hzz;

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: self-checking bench for irq_arbiter (NUM_SRC=4, base E0).
// Register access is table driven; read data and SRC_ACK pulses are checked
// by a monitor against scoreboard queues filled when the stimulus is driven.
module tb_irq_arbiter;
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       hit;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        int         tag;
    } rd_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] bus_data;
    logic [7:0] tb_drv = 8'h00;
    logic       tb_oe = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       we = 1'b0;
    logic [3:0] src = 4'h0;
    logic [3:0] src_ack;
    logic       irq_raise;
    logic       irq_ack = 1'b0;
    logic       mon_en = 1'b0;
    logic       rd_issue = 1'b0;
    logic       rd_pipe = 1'b0;

    int checks = 0;
    int failures = 0;
    int rd_tag = 0;
    rd_t rd_sb[$];
    int  ack_sb[$];

    vec_t reset_tbl[6];
    vec_t rw_tbl[15];

    assign bus_data = tb_oe ? tb_drv : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) rd_pipe <= rd_issue;

    irq_arbiter #(.NUM_SRC(4), .BASE_ADDR(8'hE0)) dut (
        .CLK(clk), .RESET(reset), .BUS_DATA(bus_data), .BUS_ADDR(addr),
        .BUS_WE(we), .SRC_RAISE(src), .SRC_ACK(src_ack),
        .IRQ_RAISE(irq_raise), .IRQ_ACK(irq_ack)
    );

    function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [7:0] d, input logic h);
        vec_t v;
        v.we = w; v.addr = a; v.data = d; v.hit = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; we = 1'b1; tb_drv = d; tb_oe = 1'b1;
        @(negedge clk);
        we = 1'b0; tb_oe = 1'b0; addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic h, input logic [7:0] e);
        rd_t r;
        @(negedge clk);
        addr = a; we = 1'b0; rd_issue = h;
        if (h) begin
            r.exp = e; r.tag = rd_tag;
            rd_sb.push_back(r);
        end
        rd_tag++;
        @(negedge clk);
        addr = 8'h00; rd_issue = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        if (v.we) bus_write(v.addr, v.data);
        else      bus_read(v.addr, v.hit, v.data);
    endtask

    task automatic ack_irq(input int idx);
        @(negedge clk);
        irq_ack = 1'b1;
        ack_sb.push_back(idx);
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq_drop_after_ack", {7'd0, irq_raise}, 8'h00);
    endtask

    task automatic wait_irq(input int bound, output int cyc);
        cyc = 0;
        while (irq_raise !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk("irq_raise_seen", {7'd0, irq_raise}, 8'h01);
    endtask

    task automatic count_irq(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (irq_raise === 1'b1) hi++;
        end
    endtask

    // Monitor: read data only in the cycle after an address hit, bus
    // released otherwise, and every SRC_ACK pulse matched to a queued ACK.
    initial begin
        rd_t r;
        int  i;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (rd_pipe) begin
                    if (rd_sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL read_unqueued actual=%h required=none", bus_data);
                    end else begin
                        r = rd_sb.pop_front();
                        chk($sformatf("read_%0d", r.tag), bus_data, r.exp);
                    end
                end else if (!tb_oe) begin
                    chk("bus_released", bus_data, 8'hFF);
                end
                if (src_ack !== 4'h0) begin
                    if (ack_sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL src_ack_unexpected actual=%b required=0000", src_ack);
                    end else begin
                        i = ack_sb.pop_front();
                        chk("src_ack", {4'h0, src_ack}, 8'(1 << i));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int hi;
        int order[3];

        reset_tbl[0] = mk(1'b0, 8'hE0, 8'h0F, 1'b1);
        reset_tbl[1] = mk(1'b0, 8'hE1, 8'h00, 1'b1);
        reset_tbl[2] = mk(1'b0, 8'hE2, 8'h00, 1'b1);
        reset_tbl[3] = mk(1'b0, 8'hE3, 8'h02, 1'b1);
        reset_tbl[4] = mk(1'b0, 8'hE4, 8'h00, 1'b0);
        reset_tbl[5] = mk(1'b0, 8'hDF, 8'h00, 1'b0);

        rw_tbl[0]  = mk(1'b1, 8'hE0, 8'hFF, 1'b1);
        rw_tbl[1]  = mk(1'b0, 8'hE0, 8'h0F, 1'b1);
        rw_tbl[2]  = mk(1'b1, 8'hE0, 8'h05, 1'b1);
        rw_tbl[3]  = mk(1'b0, 8'hE0, 8'h05, 1'b1);
        rw_tbl[4]  = mk(1'b1, 8'hE0, 8'h0F, 1'b1);
        rw_tbl[5]  = mk(1'b1, 8'hE3, 8'h01, 1'b1);
        rw_tbl[6]  = mk(1'b0, 8'hE3, 8'h01, 1'b1);
        rw_tbl[7]  = mk(1'b1, 8'hE3, 8'hFF, 1'b1);
        rw_tbl[8]  = mk(1'b0, 8'hE3, 8'h03, 1'b1);
        rw_tbl[9]  = mk(1'b1, 8'hE3, 8'h02, 1'b1);
        rw_tbl[10] = mk(1'b0, 8'hE3, 8'h02, 1'b1);
        rw_tbl[11] = mk(1'b1, 8'hE2, 8'hFF, 1'b1);
        rw_tbl[12] = mk(1'b0, 8'hE2, 8'h00, 1'b1);
        rw_tbl[13] = mk(1'b1, 8'hE1, 8'hFF, 1'b1);
        rw_tbl[14] = mk(1'b0, 8'hE1, 8'h00, 1'b1);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        chk("irq_after_reset", {7'd0, irq_raise}, 8'h00);

        for (int i = 0; i < 6; i++) apply(reset_tbl[i]);

        // IRQ_ACK while idle must not produce any SRC_ACK
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        chk("irq_ack_idle", {7'd0, irq_raise}, 8'h00);

        for (int i = 0; i < 15; i++) apply(rw_tbl[i]);

        // Single source 2: latency, vector, ack, clean-up
        @(negedge clk); src[2] = 1'b1;
        wait_irq(10, cyc);
        chk("irq_latency", 8'(cyc), 8'd3);
        bus_read(8'hE2, 1'b1, 8'h82);
        ack_irq(2);
        src[2] = 1'b0;
        bus_read(8'hE1, 1'b1, 8'h00);
        bus_read(8'hE2, 1'b1, 8'h02);

        // Fixed priority: 3 and 1 together -> 1 then 3, 3-cycle spacing
        @(negedge clk); src[3] = 1'b1; src[1] = 1'b1;
        wait_irq(10, cyc);
        bus_read(8'hE2, 1'b1, 8'h81);
        ack_irq(1);
        src[1] = 1'b0;
        wait_irq(10, cyc);
        chk("irq_spacing", 8'(cyc), 8'd3);
        bus_read(8'hE2, 1'b1, 8'h83);
        ack_irq(3);
        src[3] = 1'b0;

        // Masked source stays pending; unmasking issues it (rr_ptr ends at 2)
        bus_write(8'hE0, 8'h0D);
        @(negedge clk); src[1] = 1'b1;
        count_irq(6, hi);
        chk("masked_no_irq", 8'(hi), 8'd0);
        bus_read(8'hE1, 1'b1, 8'h02);
        bus_write(8'hE0, 8'h0F);
        wait_irq(10, cyc);
        bus_read(8'hE2, 1'b1, 8'h81);
        ack_irq(1);
        src[1] = 1'b0;

        // Round-robin from rr_ptr=2 with 0,1,3 pending -> 3,0,1
        bus_write(8'hE3, 8'h00);
        @(negedge clk); src = 4'b1011;
        bus_write(8'hE3, 8'h03);
        order[0] = 3; order[1] = 0; order[2] = 1;
        for (int i = 0; i < 3; i++) begin
            wait_irq(12, cyc);
            bus_read(8'hE2, 1'b1, 8'h80 | 8'(order[i]));
            ack_irq(order[i]);
        end
        bus_read(8'hE1, 1'b1, 8'h00);
        src = 4'h0;
        bus_write(8'hE3, 8'h02);

        // Committed grant: MASK and W1C in RAISE do not withdraw source 0
        @(negedge clk); src[0] = 1'b1;
        wait_irq(10, cyc);
        bus_write(8'hE0, 8'h00);
        bus_write(8'hE1, 8'h01);
        chk("irq_committed", {7'd0, irq_raise}, 8'h01);
        bus_read(8'hE1, 1'b1, 8'h01);
        chk("irq_still_committed", {7'd0, irq_raise}, 8'h01);
        ack_irq(0);
        src[0] = 1'b0;
        bus_read(8'hE1, 1'b1, 8'h00);
        bus_write(8'hE0, 8'h0F);

        // Disabled: capture still happens, set beats a same-cycle W1C
        bus_write(8'hE3, 8'h00);
        @(negedge clk);
        addr = 8'hE1; we = 1'b1; tb_drv = 8'h02; tb_oe = 1'b1; src[1] = 1'b1;
        @(negedge clk);
        we = 1'b0; tb_oe = 1'b0; addr = 8'h00;
        bus_read(8'hE1, 1'b1, 8'h02);
        count_irq(5, hi);
        chk("disabled_no_irq", 8'(hi), 8'd0);

        // Enable, then reset in RAISE: IRQ drops, no SRC_ACK, reset values
        bus_write(8'hE3, 8'h02);
        wait_irq(10, cyc);
        @(negedge clk); reset = 1'b1; src = 4'h0;
        @(negedge clk);
        chk("irq_after_mid_reset", {7'd0, irq_raise}, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) apply(reset_tbl[i]);
        count_irq(4, hi);
        chk("idle_after_reset", 8'(hi), 8'd0);

        repeat (3) @(negedge clk);
        chk("rd_sb_drained", 8'(rd_sb.size()), 8'd0);
        chk("ack_sb_drained", 8'(ack_sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
